// File: rtl/bram_stream_reader.sv
// Burst reader for the simple dual-port BRAM read port: (base, length) request in, valid/ready stream out.
// Macro BRAM_RD_OUTREG_EN selects 2-cycle read latency (output register); reads are credit-gated so the skid FIFO never overflows.
`timescale 1ns/1ps

module bram_stream_reader #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 25088,
  parameter int ADDR_W     = 15,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clka,
  input  logic              rstb,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  output logic              regceb,
  input  logic [DATA_W-1:0] doutb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

`ifdef BRAM_RD_OUTREG_EN
  localparam int LAT = 2;
  assign regceb = rstb;
`else
  localparam int LAT = 1;
  assign regceb = 1'b0;
`endif
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + LAT + 2) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d, next_addr_q, next_addr_d;
  logic              enb_q, enb_d, last_iss_q, last_iss_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [LAT-1:0]    vld_sr_q, vld_sr_d, last_sr_q, last_sr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last_q, mem_last_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]     occ;
  logic              push, pop, head_last;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push      = vld_sr_q[LAT-1];
  assign m_valid   = (fifo_cnt_q != '0);
  assign pop       = m_valid && m_ready;
  assign head_last = mem_last_q[rd_ptr_q];
  assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
  assign m_last    = m_valid && head_last;
  assign busy      = busy_q;
  assign done      = done_q;
  assign addrb     = addrb_q;
  assign enb       = enb_q;

  always_comb begin
    // Occupancy next cycle: FIFO after this pop, plus every read already issued and not yet pushed.
    occ = fifo_cnt_q + CW'(enb_q) - CW'(pop);
    for (int i = 0; i < LAT; i++) occ = occ + CW'(vld_sr_q[i]);

    state_d     = state_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    addrb_d     = addrb_q;
    next_addr_d = next_addr_q;
    enb_d       = 1'b0;
    last_iss_d  = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            len_d       = length;
            enb_d       = 1'b1;
            addrb_d     = base_addr;
            next_addr_d = addr_inc(base_addr);
            issue_cnt_d = LEN_W'(1);
            last_iss_d  = (length == LEN_W'(1));
            state_d     = (length == LEN_W'(1)) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (occ < CW'(FIFO_DEPTH)) begin
          enb_d       = 1'b1;
          addrb_d     = next_addr_q;
          next_addr_d = addr_inc(next_addr_q);
          issue_cnt_d = issue_cnt_q + LEN_W'(1);
          last_iss_d  = (issue_cnt_q == len_q - LEN_W'(1));
          if (last_iss_d) state_d = DRAIN;
        end
      end
      default: ;
    endcase

    if (state_q != IDLE && pop && head_last) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    busy_d = (state_d != IDLE);

    vld_sr_d  = LAT'({vld_sr_q, enb_q});
    last_sr_d = LAT'({last_sr_q, enb_q && last_iss_q});

    mem_d      = mem_q;
    mem_last_d = mem_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q]      = doutb;
      mem_last_d[wr_ptr_q] = last_sr_q[LAT-1];
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clka) begin
    if (!rstb) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issue_cnt_q <= '0;
      addrb_q     <= '0;
      next_addr_q <= '0;
      enb_q       <= 1'b0;
      last_iss_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
      mem_q       <= '{default: '0};
      mem_last_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      addrb_q     <= addrb_d;
      next_addr_q <= next_addr_d;
      enb_q       <= enb_d;
      last_iss_q  <= last_iss_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vld_sr_q    <= vld_sr_d;
      last_sr_q   <= last_sr_d;
      mem_q       <= mem_d;
      mem_last_q  <= mem_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  fifo_no_overflow: assert property (@(posedge clka) disable iff (!rstb)
    !(push && !pop && fifo_cnt_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural BRAM read port in the matching latency mode.
`timescale 1ns/1ps

module tb_bram_stream_reader;
`ifdef BRAM_RD_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 25088;
  localparam int FD    = 4;

  logic        clka = 1'b0;
  logic        rstb, start, m_ready;
  logic [14:0] base_addr;
  logic [15:0] length;
  logic        busy, done, enb, regceb, m_valid, m_last;
  logic [14:0] addrb;
  logic [63:0] doutb, m_data;

  bram_stream_reader dut (
    .clka(clka), .rstb(rstb), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .addrb(addrb), .enb(enb), .regceb(regceb), .doutb(doutb),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clka = ~clka;

  function automatic logic [63:0] data_of(input logic [14:0] a);
    return {16'hC0DE, 1'b0, a, 1'b1, ~a, 16'h5A5A};
  endfunction

  logic [63:0] ram_out;
  always @(posedge clka) if (enb) ram_out <= data_of(addrb);
`ifdef BRAM_RD_OUTREG_EN
  logic [63:0] ram_reg;
  always @(posedge clka) if (!rstb) ram_reg <= '0; else if (regceb) ram_reg <= ram_out;
  assign doutb = ram_reg;
`else
  assign doutb = ram_out;
`endif

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int pass = 0, total = 0, t0 = 0;
  logic [63:0] pat = 64'hA5C3_96F0_3C5A_E187;

  logic [14:0] addr_q[$];
  logic [63:0] dat_q[$];
  bit          last_q[$];
  int en_cnt, hs_cnt, done_cnt, done_cyc, last_hs_cyc, first_v_cyc, max_out, stab_err, busy_seen, busy_done_err;
  logic [63:0] prev_data;
  logic        prev_last;
  bit          prev_stall;

  task automatic clear_mon();
    addr_q.delete(); dat_q.delete(); last_q.delete();
    en_cnt = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; first_v_cyc = -1;
    max_out = 0; stab_err = 0; busy_seen = 0; busy_done_err = 0; prev_stall = 0;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clka);
      if (enb === 1'b1) begin addr_q.push_back(addrb); en_cnt++; end
      if (m_valid === 1'b1 && first_v_cyc < 0) first_v_cyc = cyc;
      if (prev_stall && m_valid === 1'b1 && (m_data !== prev_data || m_last !== prev_last)) stab_err++;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        dat_q.push_back(m_data); last_q.push_back(m_last); hs_cnt++;
        if (m_last === 1'b1) last_hs_cyc = cyc;
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; if (busy !== 1'b0) busy_done_err++; end
      if (busy === 1'b1) busy_seen++;
      if (en_cnt - hs_cnt > max_out) max_out = en_cnt - hs_cnt;
      prev_stall = (m_valid === 1'b1 && m_ready === 1'b0);
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // mode 0: ready held high; mode 1: ready follows pat; mode 2: ready high plus a second start mid-burst.
  task automatic do_burst(input logic [14:0] b, input logic [15:0] l, input int mode, output bit to);
    clear_mon();
    base_addr = b; length = l; start = 1'b1;
    m_ready = (mode == 1) ? pat[0] : 1'b1;
    @(posedge clka); #1;
    start = 1'b0; t0 = cyc; to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt > 0) begin to = 1'b0; break; end
      m_ready = (mode == 1) ? pat[(i + 1) % 64] : 1'b1;
      if (mode == 2 && i == 5) begin base_addr = 15'd100; length = 16'd7; start = 1'b1; end
      else start = 1'b0;
      @(posedge clka); #1;
    end
    start = 1'b0; m_ready = 1'b1;
    repeat (4) @(posedge clka);
    #1;
  endtask

  task automatic test_reset();
    logic exp_rce;
    rstb = 1'b0; start = 1'b0; m_ready = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(posedge clka);
    @(negedge clka);
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass++;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass++;
    total++; if (enb !== 1'b0) $display("FAIL rst_enb: got %b want 0", enb); else pass++;
    total++; if (addrb !== 15'd0) $display("FAIL rst_addrb: got %0d want 0", addrb); else pass++;
    total++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid); else pass++;
    total++; if (m_last !== 1'b0) $display("FAIL rst_m_last: got %b want 0", m_last); else pass++;
    total++; if (m_data !== 64'd0) $display("FAIL rst_m_data: got %h want 0", m_data); else pass++;
    total++; if (regceb !== 1'b0) $display("FAIL rst_regceb: got %b want 0", regceb); else pass++;
    @(posedge clka); #1;
    rstb = 1'b1;
    @(negedge clka);
    exp_rce = (LAT == 2);
    total++; if (regceb !== exp_rce) $display("FAIL run_regceb: got %b want %b", regceb, exp_rce); else pass++;
    @(posedge clka); #1;
  endtask

  task automatic test_basic();
    bit to;
    do_burst(15'd10, 16'd8, 0, to);
    total++; if (to) $display("FAIL basic_timeout: no done within budget"); else pass++;
    total++; if (addr_q.size() != 8) $display("FAIL basic_enb_count: got %0d want 8", addr_q.size()); else pass++;
    total++; if (dat_q.size() != 8) $display("FAIL basic_word_count: got %0d want 8", dat_q.size()); else pass++;
    for (int i = 0; i < addr_q.size() && i < 8; i++) begin
      total++; if (addr_q[i] !== 15'(10 + i)) $display("FAIL basic_addr%0d: got %0d want %0d", i, addr_q[i], 10 + i); else pass++;
    end
    for (int i = 0; i < dat_q.size() && i < 8; i++) begin
      total++; if (dat_q[i] !== data_of(15'(10 + i))) $display("FAIL basic_data%0d: got %h want %h", i, dat_q[i], data_of(15'(10 + i))); else pass++;
      total++; if (last_q[i] !== (i == 7)) $display("FAIL basic_last%0d: got %b want %b", i, last_q[i], (i == 7)); else pass++;
    end
    total++; if (first_v_cyc - t0 + 1 != 2 + LAT) $display("FAIL basic_first_valid: got cycle %0d want %0d", first_v_cyc - t0 + 1, 2 + LAT); else pass++;
    total++; if (last_hs_cyc - t0 + 1 != 9 + LAT) $display("FAIL basic_last_hs: got cycle %0d want %0d", last_hs_cyc - t0 + 1, 9 + LAT); else pass++;
    total++; if (done_cyc - t0 + 1 != 10 + LAT) $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc - t0 + 1, 10 + LAT); else pass++;
    total++; if (done_cnt != 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt); else pass++;
    total++; if (busy_done_err != 0) $display("FAIL basic_busy_at_done: got %0d cycles busy with done, want 0", busy_done_err); else pass++;
  endtask

  task automatic test_wrap();
    bit to;
    do_burst(15'(DEPTH - 3), 16'd6, 0, to);
    total++; if (to) $display("FAIL wrap_timeout: no done within budget"); else pass++;
    total++; if (addr_q.size() != 6 || dat_q.size() != 6) $display("FAIL wrap_count: got %0d/%0d want 6/6", addr_q.size(), dat_q.size()); else pass++;
    for (int i = 0; i < addr_q.size() && i < dat_q.size() && i < 6; i++) begin
      total++; if (addr_q[i] !== 15'((DEPTH - 3 + i) % DEPTH)) $display("FAIL wrap_addr%0d: got %0d want %0d", i, addr_q[i], (DEPTH - 3 + i) % DEPTH); else pass++;
      total++; if (dat_q[i] !== data_of(15'((DEPTH - 3 + i) % DEPTH))) $display("FAIL wrap_data%0d: got %h want %h", i, dat_q[i], data_of(15'((DEPTH - 3 + i) % DEPTH))); else pass++;
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int bad;
    do_burst(15'd200, 16'd32, 1, to);
    total++; if (to) $display("FAIL bp_timeout: no done within budget"); else pass++;
    total++; if (dat_q.size() != 32) $display("FAIL bp_word_count: got %0d want 32", dat_q.size()); else pass++;
    bad = 0;
    for (int i = 0; i < dat_q.size(); i++)
      if (dat_q[i] !== data_of(15'(200 + i)) || last_q[i] !== (i == 31)) bad++;
    total++; if (bad != 0) $display("FAIL bp_data_order: got %0d wrong words want 0", bad); else pass++;
    total++; if (max_out != FD) $display("FAIL bp_outstanding: got max %0d want %0d", max_out, FD); else pass++;
    total++; if (en_cnt != 32) $display("FAIL bp_enb_count: got %0d want 32", en_cnt); else pass++;
    total++; if (stab_err != 0) $display("FAIL bp_stall_stable: got %0d changes want 0", stab_err); else pass++;
    total++; if (done_cnt != 1 || done_cyc - last_hs_cyc != 1) $display("FAIL bp_done: got count %0d gap %0d want 1/1", done_cnt, done_cyc - last_hs_cyc); else pass++;
  endtask

  task automatic test_zero_len();
    bit to;
    do_burst(15'd55, 16'd0, 0, to);
    total++; if (to) $display("FAIL zero_timeout: no done within budget"); else pass++;
    total++; if (done_cnt != 1) $display("FAIL zero_done_count: got %0d want 1", done_cnt); else pass++;
    total++; if (done_cyc - t0 + 1 != 1) $display("FAIL zero_done_cycle: got %0d want 1", done_cyc - t0 + 1); else pass++;
    total++; if (busy_seen != 0) $display("FAIL zero_busy: got %0d busy cycles want 0", busy_seen); else pass++;
    total++; if (en_cnt != 0) $display("FAIL zero_enb: got %0d reads want 0", en_cnt); else pass++;
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_mon();
    base_addr = 15'd300; length = 16'd20; start = 1'b1; m_ready = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && hs_cnt < 4; i++) begin
      @(posedge clka); #1;
    end
    total++; if (hs_cnt < 4) $display("FAIL rmid_progress: got %0d words want 4", hs_cnt); else pass++;
    rstb = 1'b0;
    @(posedge clka); #1;
    rstb = 1'b1;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else pass++;
    total++; if (done !== 1'b0) $display("FAIL rmid_done: got %b want 0", done); else pass++;
    total++; if (enb !== 1'b0) $display("FAIL rmid_enb: got %b want 0", enb); else pass++;
    total++; if (addrb !== 15'd0) $display("FAIL rmid_addrb: got %0d want 0", addrb); else pass++;
    total++; if (m_valid !== 1'b0) $display("FAIL rmid_m_valid: got %b want 0", m_valid); else pass++;
    total++; if (m_last !== 1'b0) $display("FAIL rmid_m_last: got %b want 0", m_last); else pass++;
    total++; if (m_data !== 64'd0) $display("FAIL rmid_m_data: got %h want 0", m_data); else pass++;
    clear_mon();
    repeat (6) @(posedge clka);
    #1;
    total++; if (done_cnt + hs_cnt + en_cnt != 0) $display("FAIL rmid_quiet: got done %0d words %0d reads %0d want 0", done_cnt, hs_cnt, en_cnt); else pass++;
    do_burst(15'd0, 16'd4, 0, to);
    total++; if (to) $display("FAIL rmid_new_timeout: no done within budget"); else pass++;
    total++; if (dat_q.size() != 4) $display("FAIL rmid_new_count: got %0d want 4", dat_q.size()); else pass++;
    for (int i = 0; i < dat_q.size() && i < 4; i++) begin
      total++; if (dat_q[i] !== data_of(15'(i))) $display("FAIL rmid_new_data%0d: got %h want %h", i, dat_q[i], data_of(15'(i))); else pass++;
    end
  endtask

  task automatic test_start_busy();
    bit to;
    int bad;
    do_burst(15'd400, 16'd20, 2, to);
    total++; if (to) $display("FAIL sbusy_timeout: no done within budget"); else pass++;
    total++; if (dat_q.size() != 20) $display("FAIL sbusy_word_count: got %0d want 20", dat_q.size()); else pass++;
    bad = 0;
    for (int i = 0; i < dat_q.size(); i++) if (dat_q[i] !== data_of(15'(400 + i))) bad++;
    total++; if (bad != 0) $display("FAIL sbusy_data: got %0d wrong words want 0", bad); else pass++;
    total++; if (en_cnt != 20) $display("FAIL sbusy_enb_count: got %0d want 20", en_cnt); else pass++;
    total++; if (done_cnt != 1) $display("FAIL sbusy_done_count: got %0d want 1", done_cnt); else pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_start_busy();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", pass, total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side controller for the simple dual-port BRAM: drives the BRAM read port (addrb, enb, regceb) and turns a burst request (base address, length) into a valid/ready output stream. It hides the BRAM read latency (1 or 2 cycles) behind a credit-controlled skid FIFO, so downstream backpressure never drops or duplicates a word. It sits between the NPU buffer BRAMs and the compute-array or DMA consumers.

## Interface
- DATA_W, 64: BRAM word width; equals the BRAM's RAM_WIDTH.
- DEPTH, 25088: BRAM depth; addresses wrap modulo DEPTH.
- ADDR_W, 15: address width; equals clogb2(DEPTH-1).
- LEN_W, 16: burst-length width.
- FIFO_DEPTH, 4: skid FIFO entries; must be at least LAT+2, where LAT is 1 or 2 (see Configuration).
- clka  in  1  clock.
- rstb  in  1  reset, synchronous, active-low; clock clka. It also feeds the BRAM output-register reset.
- start  in  1  one-cycle burst request; sampled only in IDLE.
- base_addr  in  ADDR_W  first address; must be below DEPTH.
- length  in  LEN_W  number of words; 0 is legal.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the burst completes.
- addrb  out  ADDR_W  BRAM read address.
- enb  out  1  BRAM read enable; one pulse per word read.
- regceb  out  1  BRAM output-register enable.
- doutb  in  DATA_W  BRAM read data.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  DATA_W  stream word (FIFO head).
- m_last  out  1  marks the final word of the burst.

## Operation
- Reset values: busy=0, done=0, enb=0, addrb=0, m_valid=0, m_last=0, m_data=0. regceb is 0 while rstb=0. The FIFO is empty, all counters are 0, and the state is IDLE.
- States:
  - IDLE: on start with length≠0, latch base_addr and length, then go to RUN. On start with length=0, pulse done on the next cycle and stay in IDLE.
  - RUN: issue reads. After the last read is issued, go to DRAIN.
  - DRAIN: when the last word is accepted (m_valid && m_ready && m_last), go to IDLE and pulse done on the following cycle.
- start while busy is ignored. Inputs are not re-sampled during a burst.
- Issue rule:
  - Each cycle in RUN, assert enb iff fifo_count + inflight + issued_this_cycle < FIFO_DEPTH.
  - addrb increments after each issue and wraps from DEPTH-1 to 0.
  - issue_cnt counts up to the latched length.
- In-flight tracking: a LAT-stage valid shift register follows each enb. The word at doutb is pushed into the FIFO on the cycle its shift-register bit exits.
- The FIFO pushes only tracked words, so no credit overflow is possible. An overflow is an assertion failure.
- m_last travels with the word tagged issue_cnt == length-1.
- Simultaneous FIFO push and pop leaves the count unchanged. A push into a full FIFO with a simultaneous pop is legal.
- Reset mid-burst: all state is cleared next edge and the FIFO is flushed. BRAM words still in flight are dropped, and done is not pulsed.

## Timing
- start sampled at edge 0. The first enb/addrb=base is driven in the following cycle (cycle 1).
- The first m_valid appears in cycle 2+LAT.
- With m_ready held high, throughput is 1 word/cycle, with no bubbles, provided FIFO_DEPTH ≥ LAT+2.
- After m_ready is deasserted, enb stops within one cycle once credits are exhausted. At most FIFO_DEPTH words are buffered.
- m_data and m_last are stable while m_valid=1 and m_ready=0.
- done goes high exactly one cycle after the last handshake. busy falls in that same cycle.

## Configuration
- BRAM_RD_OUTREG_EN: defined means LAT=2 and regceb is driven high whenever rstb=1, matching the BRAM in HIGH_PERFORMANCE mode.
- Undefined means LAT=1 and regceb is held 0, matching LOW_LATENCY mode.
- The bench must instantiate the BRAM in the matching mode.

## Test plan
- base=10, length=8, m_ready=1: addrb runs 10..17 on consecutive cycles. m_data equals BRAM[10..17] in order. m_last is high on word 8. done fires 1 cycle after that handshake. The first m_valid is at cycle 3 (macro off) or cycle 4 (macro on).
- base=DEPTH-3, length=6: addrb sequence is DEPTH-3, DEPTH-2, DEPTH-1, 0, 1, 2, and the data matches.
- length=32, with m_ready toggled by a random 50% pattern: all 32 words are delivered exactly once, in order. fifo_count never exceeds FIFO_DEPTH. enb stalls while credits are 0.
- length=0: done pulses once at cycle 1, busy stays 0, and enb never asserts.
- rstb low for one cycle during burst word 5 of 20: all outputs are at their reset values next cycle. A new start with base=0, length=4 then delivers BRAM[0..3] with no stale words.
- A start pulse while busy (length=20 active, second start base=100): it is ignored, exactly 20 words are delivered, and a single done pulse occurs.
